// File: rtl/fpu_ret_collect.sv
// FP retire-tag collector: merges up to three lane retirements per cycle into
// an in-order circular queue drained by the retire unit, one entry per cycle.
// Optional build macro FPRET_STICKY_EN accumulates popped exception flags into
// fpcsr_sticky; without it fpcsr_sticky is tied to zero.
module fpu_ret_collect #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] u1_ret,
  input  logic [13:0] u3_ret,
  input  logic [13:0] u5_ret,
  input  logic        u1_ret_en,
  input  logic        u3_ret_en,
  input  logic        u5_ret_en,
  input  logic [5:0]  FOOFL0,
  input  logic [5:0]  FOOFL1,
  input  logic [5:0]  FOOFL2,
  output logic        in_stall,
  output logic        out_valid,
  output logic [13:0] out_ret,
  output logic [5:0]  out_flags,
  input  logic        out_ready,
  input  logic        sticky_clr,
  output logic [5:0]  fpcsr_sticky,
  output logic        ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 20;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [2:0]    lane_en;
  logic [EW-1:0] lane_dat [3];
  logic [CW-1:0] space;
  logic [1:0]    n_push;
  logic [PW-1:0] wa;
  logic          drop;
  logic          pop_c;
  logic [EW-1:0] head;

  // Head of queue and status, all derived from registered pointers/count
  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign out_ret   = head[13:0];
  assign out_flags = head[19:14];
  assign in_stall  = (count_q > CW'(DEPTH - 3));
  assign ovf       = ovf_q;
  assign pop_c     = out_valid && out_ready;

  // Pack lanes in fixed priority u1, u3, u5; excess beyond free space is dropped
  always_comb begin
    lane_en     = {u5_ret_en, u3_ret_en, u1_ret_en};
    lane_dat[0] = {FOOFL0, u1_ret};
    lane_dat[1] = {FOOFL1, u3_ret};
    lane_dat[2] = {FOOFL2, u5_ret};
    space       = CW'(DEPTH) - count_q + CW'(pop_c);
    mem_d       = mem_q;
    n_push      = '0;
    drop        = 1'b0;
    wa          = wr_ptr_q;
    for (int i = 0; i < 3; i++) begin
      if (lane_en[i]) begin
        if (CW'(n_push) < space) begin
          wa        = wr_ptr_q + PW'(n_push);
          mem_d[wa] = lane_dat[i];
          n_push    = n_push + 2'd1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    wr_ptr_d = wr_ptr_q + PW'(n_push);
    rd_ptr_d = rd_ptr_q + PW'(pop_c);
    count_d  = count_q + CW'(n_push) - CW'(pop_c);
    ovf_d    = ovf_q | drop;
  end

  // Pointer, occupancy and overflow state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage; contents are meaningless while count is zero, so no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef FPRET_STICKY_EN
  logic [5:0] sticky_q, sticky_d;

  // Clear takes effect before the popped entry's flags are merged in
  always_comb begin
    sticky_d = sticky_clr ? 6'd0 : sticky_q;
    if (pop_c) begin
      sticky_d = sticky_d | out_flags;
    end
  end

  // Accumulated exception flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign fpcsr_sticky = sticky_q;
`else
  logic sticky_clr_unused;
  assign sticky_clr_unused = sticky_clr;
  assign fpcsr_sticky      = '0;
`endif

endmodule

// File: tb/tb_fpu_ret_collect.sv
// Randomized + directed bench for fpu_ret_collect against a queue-based model.
// Build with FPRET_STICKY_EN defined to exercise the sticky-flag feature.
module tb_fpu_ret_collect;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] u1_ret, u3_ret, u5_ret;
  logic        u1_ret_en, u3_ret_en, u5_ret_en;
  logic [5:0]  FOOFL0, FOOFL1, FOOFL2;
  logic        in_stall, out_valid, out_ready, sticky_clr, ovf;
  logic [13:0] out_ret;
  logic [5:0]  out_flags, fpcsr_sticky;

  int n_vec = 0;
  int n_err = 0;

  logic [19:0] mq [$];
  logic        m_ovf;
  logic [5:0]  m_sticky;

  fpu_ret_collect #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .u1_ret(u1_ret), .u3_ret(u3_ret), .u5_ret(u5_ret),
    .u1_ret_en(u1_ret_en), .u3_ret_en(u3_ret_en), .u5_ret_en(u5_ret_en),
    .FOOFL0(FOOFL0), .FOOFL1(FOOFL1), .FOOFL2(FOOFL2),
    .in_stall(in_stall), .out_valid(out_valid), .out_ret(out_ret),
    .out_flags(out_flags), .out_ready(out_ready), .sticky_clr(sticky_clr),
    .fpcsr_sticky(fpcsr_sticky), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every observable output against the model state
  task automatic check_outs(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk({tag, ".ret"},   32'(out_ret),   32'(mq[0][13:0]));
      chk({tag, ".flags"}, 32'(out_flags), 32'(mq[0][19:14]));
    end
    chk({tag, ".stall"},  32'(in_stall),     32'(mq.size() > int'(DEPTH) - 3));
    chk({tag, ".ovf"},    32'(ovf),          32'(m_ovf));
    chk({tag, ".sticky"}, 32'(fpcsr_sticky), 32'(m_sticky));
  endtask

  // Drive one cycle of inputs (called at negedge), advance model, check at next negedge
  task automatic cyc(input string tag,
                     input logic e1, input logic e3, input logic e5,
                     input logic [13:0] t1, input logic [13:0] t3, input logic [13:0] t5,
                     input logic [5:0] f1, input logic [5:0] f3, input logic [5:0] f5,
                     input logic rdy, input logic clr);
    logic        pop;
    logic [5:0]  pf;
    u1_ret_en = e1; u3_ret_en = e3; u5_ret_en = e5;
    u1_ret = t1; u3_ret = t3; u5_ret = t5;
    FOOFL0 = f1; FOOFL1 = f3; FOOFL2 = f5;
    out_ready = rdy; sticky_clr = clr;
    pop = (mq.size() != 0) && rdy;
    pf  = 6'd0;
    if (pop) begin
      pf = mq[0][19:14];
      void'(mq.pop_front());
    end
`ifdef FPRET_STICKY_EN
    if (clr) m_sticky = 6'd0;
    m_sticky = m_sticky | pf;
`endif
    if (e1) begin if (mq.size() < int'(DEPTH)) mq.push_back({f1, t1}); else m_ovf = 1'b1; end
    if (e3) begin if (mq.size() < int'(DEPTH)) mq.push_back({f3, t3}); else m_ovf = 1'b1; end
    if (e5) begin if (mq.size() < int'(DEPTH)) mq.push_back({f5, t5}); else m_ovf = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    check_outs(tag);
  endtask

  task automatic idle(input string tag, input logic rdy, input logic clr);
    cyc(tag, 1'b0, 1'b0, 1'b0, 14'd0, 14'd0, 14'd0, 6'd0, 6'd0, 6'd0, rdy, clr);
  endtask

  task automatic push3(input string tag, input logic [13:0] base, input logic rdy);
    cyc(tag, 1'b1, 1'b1, 1'b1, base, base + 14'd1, base + 14'd2,
        6'h01, 6'h02, 6'h04, rdy, 1'b0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf    = 1'b0;
    m_sticky = 6'd0;
  endtask

  initial begin
    rst = 1'b0;
    u1_ret_en = 0; u3_ret_en = 0; u5_ret_en = 0;
    u1_ret = 0; u3_ret = 0; u5_ret = 0;
    FOOFL0 = 0; FOOFL1 = 0; FOOFL2 = 0;
    out_ready = 0; sticky_clr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outs("reset");
    rst = 1'b1;

    // Single push, one-cycle latency
    cyc("single", 1, 0, 0, 14'h0123, 0, 0, 6'h05, 0, 0, 1'b0, 1'b0);
    idle("single_drain", 1'b1, 1'b0);

    // Lane ordering u1, u3, u5
    cyc("order", 1, 1, 1, 14'h10, 14'h20, 14'h30, 6'h3, 6'h5, 6'h6, 1'b1, 1'b0);
    repeat (4) idle("order_drain", 1'b1, 1'b0);

    // Stall threshold and pointer wrap
    push3("stall_a", 14'h100, 1'b0);
    push3("stall_b", 14'h200, 1'b0);
    idle("stall_pop", 1'b1, 1'b0);
    push3("wrap_fill", 14'h300, 1'b0);
    repeat (9) idle("wrap_drain", 1'b1, 1'b0);

    // Overflow: fill to 7 then offer three lanes
    push3("ovf_a", 14'h400, 1'b0);
    push3("ovf_b", 14'h500, 1'b0);
    cyc("ovf_c", 1, 0, 0, 14'h600, 0, 0, 6'h08, 0, 0, 1'b0, 1'b0);
    push3("ovf_hit", 14'h700, 1'b0);
    repeat (9) idle("ovf_drain", 1'b1, 1'b0);

    // Sticky: clear and pop in same cycle keeps popped flags
    cyc("stk_push", 1, 1, 0, 14'h11, 14'h22, 0, 6'h01, 6'h10, 0, 1'b0, 1'b0);
    idle("stk_pop1", 1'b1, 1'b0);
    idle("stk_pop2_clr", 1'b1, 1'b1);
    idle("stk_idle", 1'b0, 1'b0);

    // Asynchronous reset mid-stream
    push3("rst_a", 14'h800, 1'b0);
    cyc("rst_b", 1, 0, 0, 14'h900, 0, 0, 6'h01, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    model_reset();
    #1;
    check_outs("async_rst");
    #2;
    rst = 1'b1;
    cyc("post_rst", 1, 0, 0, 14'h0123, 0, 0, 6'h05, 0, 0, 1'b0, 1'b0);
    idle("post_rst_drain", 1'b1, 1'b0);

    // Randomized traffic, mostly honouring in_stall
    for (int n = 0; n < 600; n++) begin
      logic [2:0] en;
      en = 3'($urandom);
      if (mq.size() > int'(DEPTH) - 3 && $urandom_range(0, 9) != 0) en = 3'd0;
      cyc("rand", en[0], en[1], en[2],
          14'($urandom), 14'($urandom), 14'($urandom),
          6'($urandom), 6'($urandom), 6'($urandom),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
